// File: rtl/sdio_frame_sequencer_if.sv
// Host byte stream plus serial-writer control bundle for sdio_frame_sequencer.
// slave = sequencer side, master = host/writer side.
interface sdio_frame_sequencer_if;
    logic       I_s_valid;
    logic [7:0] I_s_data;
    logic       I_s_first;
    logic       I_s_last;
    logic       O_s_ready;
    logic [7:0] O_data_8;
    logic       O_wr_en;
    logic       O_1st_byte;
    logic       O_2nd_byte;
    logic       O_last_byte;
    logic       I_1byte_done;
    logic       I_lastbyte_done;
    logic       O_busy;
    logic       O_frame_done;
    logic       O_drop_err;
    logic       O_proto_err;

    modport slave (
        input  I_s_valid, I_s_data, I_s_first, I_s_last, I_1byte_done, I_lastbyte_done,
        output O_s_ready, O_data_8, O_wr_en, O_1st_byte, O_2nd_byte, O_last_byte,
               O_busy, O_frame_done, O_drop_err, O_proto_err
    );

    modport master (
        output I_s_valid, I_s_data, I_s_first, I_s_last, I_1byte_done, I_lastbyte_done,
        input  O_s_ready, O_data_8, O_wr_en, O_1st_byte, O_2nd_byte, O_last_byte,
               O_busy, O_frame_done, O_drop_err, O_proto_err
    );
endinterface

// File: rtl/sdio_frame_sequencer.sv
// Frame sequencer: buffers host bytes and drives the serial writer's per-byte strobes.
// Latency: byte pushed into an empty FIFO reaches the writer after 1 more cycle; backpressure = FIFO full.
module sdio_frame_sequencer #(
    parameter int FIFO_AW    = 2,
    parameter int GAP_CYCLES = 2,
    parameter int STALL_MAX  = 255
) (
    input logic                   I_clk,
    input logic                   I_rst,
    sdio_frame_sequencer_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);
    localparam logic [7:0] STALL_LAST = 8'(STALL_MAX - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_STALL, ST_GAP} state_e;

    // ---------------- byte FIFO: {first, last, data} ----------------
    logic [9:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q;
    logic               fifo_full, fifo_empty, push, pop;
    logic               head_first, head_last;
    logic [7:0]         head_data;

    assign fifo_full     = (cnt_q == (FIFO_AW + 1)'(DEPTH));
    assign fifo_empty    = (cnt_q == '0);
    // Ready is forced low while reset is asserted, not just after the next edge.
    assign bus.O_s_ready = I_rst & ~fifo_full;
    assign push          = bus.I_s_valid & bus.O_s_ready;
    assign {head_first, head_last, head_data} = mem_q[rd_ptr_q];

    always_ff @(posedge I_clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.I_s_first, bus.I_s_last, bus.I_s_data};
    end

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // ---------------- sequencing FSM ----------------
    state_e     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       f1_q, f1_d, f2_q, f2_d, fl_q, fl_d;
    logic       wr_en_q, wr_en_d, last_cur_q, last_cur_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic       frame_done_q, frame_done_d, drop_err_q, drop_err_d, proto_err_q, proto_err_d;
    logic       done_q, done_rise;
    logic       idle_step, cont_step, end_frame;

    assign done_rise = bus.I_1byte_done & ~done_q;

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            state_q      <= ST_IDLE;
            data_q       <= '0;
            f1_q         <= 1'b0;
            f2_q         <= 1'b0;
            fl_q         <= 1'b0;
            wr_en_q      <= 1'b0;
            last_cur_q   <= 1'b0;
            gap_cnt_q    <= '0;
            stall_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            drop_err_q   <= 1'b0;
            proto_err_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            f1_q         <= f1_d;
            f2_q         <= f2_d;
            fl_q         <= fl_d;
            wr_en_q      <= wr_en_d;
            last_cur_q   <= last_cur_d;
            gap_cnt_q    <= gap_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            frame_done_q <= frame_done_d;
            drop_err_q   <= drop_err_d;
            proto_err_q  <= proto_err_d;
            done_q       <= bus.I_1byte_done;
        end
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        f1_d         = f1_q;
        f2_d         = f2_q;
        fl_d         = fl_q;
        wr_en_d      = wr_en_q;
        last_cur_d   = last_cur_q;
        gap_cnt_d    = gap_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        frame_done_d = 1'b0;
        drop_err_d   = 1'b0;
        proto_err_d  = 1'b0;
        pop          = 1'b0;
        idle_step    = 1'b0;
        cont_step    = 1'b0;
        end_frame    = 1'b0;

        case (state_q)
            ST_IDLE: idle_step = 1'b1;
            // The last gap cycle already behaves as IDLE so the CS-high gap is exactly GAP_CYCLES.
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = ST_IDLE;
                    idle_step = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            ST_BUSY: begin
                if (done_rise) begin
                    if (last_cur_q) begin
                        end_frame    = 1'b1;
                        frame_done_d = 1'b1;
                        proto_err_d  = fl_q & ~bus.I_lastbyte_done;
                    end else if (!fifo_empty) begin
                        cont_step = 1'b1;
                    end else begin
                        f1_d        = 1'b0;
                        f2_d        = 1'b0;
                        fl_d        = 1'b0;
                        stall_cnt_d = '0;
                        state_d     = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (!fifo_empty) begin
                    cont_step = 1'b1;
                end else begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                    if (stall_cnt_q == STALL_LAST) begin
                        end_frame   = 1'b1;
                        proto_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (idle_step && !fifo_empty) begin
            pop = 1'b1;
            if (head_first) begin
                data_d     = head_data;
                f1_d       = 1'b1;
                f2_d       = 1'b0;
                fl_d       = 1'b0;
                wr_en_d    = 1'b1;
                last_cur_d = head_last;
                state_d    = ST_BUSY;
            end else begin
                drop_err_d = 1'b1;
            end
        end

        // A new command byte inside a frame closes the current frame but stays queued.
        if (cont_step) begin
            if (head_first) begin
                end_frame   = 1'b1;
                proto_err_d = 1'b1;
            end else begin
                pop        = 1'b1;
                data_d     = head_data;
                f1_d       = 1'b0;
                f2_d       = ~head_last;
                fl_d       = head_last;
                last_cur_d = head_last;
                state_d    = ST_BUSY;
            end
        end

        if (end_frame) begin
            wr_en_d   = 1'b0;
            f1_d      = 1'b0;
            f2_d      = 1'b0;
            fl_d      = 1'b0;
            gap_cnt_d = '0;
            state_d   = ST_GAP;
        end
    end

    assign bus.O_data_8     = data_q;
    assign bus.O_wr_en      = wr_en_q;
    assign bus.O_1st_byte   = f1_q;
    assign bus.O_2nd_byte   = f2_q;
    assign bus.O_last_byte  = fl_q;
    assign bus.O_busy       = (state_q != ST_IDLE);
    assign bus.O_frame_done = frame_done_q;
    assign bus.O_drop_err   = drop_err_q;
    assign bus.O_proto_err  = proto_err_q;
endmodule
